// File: rtl/clk_ratio_monitor_pkg.sv
// Shared types and constants for the divided-clock ratio monitor.
package clk_ratio_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    ACQUIRE,
    LOCKED,
    FAULT
  } mon_state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 0.
module sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures the period of an asynchronous slow clock in clk_i cycles and
// reports lock after a run of in-tolerance periods, or a sticky fault.
module clk_ratio_monitor
  import clk_ratio_monitor_pkg::*;
#(
  parameter int RATIO      = 4,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int MAX_PERIOD = 255,
  parameter int CW         = $clog2(MAX_PERIOD + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          slow_i,
  output logic          valid_o,
  output logic [CW-1:0] period_o,
  output logic          locked_o,
  output logic          err_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int LO = (RATIO > TOL) ? (RATIO - TOL) : 0;
  localparam logic [CW:0]   LO_W  = (CW+1)'(LO);
  localparam logic [CW:0]   HI_W  = (CW+1)'(RATIO + TOL);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_PERIOD);

  function automatic logic in_tol(input logic [CW-1:0] c);
    logic [CW:0] cx;
    cx = {1'b0, c};
    return (cx >= LO_W) && (cx <= HI_W);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == MAX_C) ? c : c + CW'(1);
  endfunction

  mon_state_e    state, state_next;
  logic [GW-1:0] good_cnt, good_next;
  logic [CW-1:0] cnt;
  logic          slow_p0, slow_p1;
  logic [1:0]    prime;
  logic          rise, match, timeout, meas, fault_set;

  // Stage p0: synchronized slow clock
  sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (slow_i),
    .q     (slow_p0)
  );

  // Stage p1: edge detect; ignore rises until the sync chain and slow_p1
  // hold real samples, so a slow_i held high across reset is not an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slow_p1 <= 1'b0;
      prime   <= 2'd0;
    end else begin
      slow_p1 <= slow_p0;
      if (prime != 2'd3) prime <= prime + 2'd1;
    end
  end

  assign rise    = slow_p0 & ~slow_p1 & (prime == 2'd3);
  assign match   = in_tol(cnt);
  assign timeout = (cnt == MAX_C) && !rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    meas       = 1'b0;
    fault_set  = 1'b0;
    if (clr_i) begin
      state_next = en_i ? ARMED : IDLE;
      good_next  = '0;
    end else if (!en_i) begin
      state_next = IDLE;
      good_next  = '0;
    end else begin
      case (state)
        IDLE:    state_next = ARMED;
        ARMED:   if (rise) state_next = ACQUIRE;
        ACQUIRE: begin
          if (rise) begin
            meas = 1'b1;
            if (!match) begin
              good_next = '0;
            end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
              state_next = LOCKED;
              good_next  = '0;
            end else begin
              good_next = good_cnt + GW'(1);
            end
          end else if (timeout) begin
            good_next = '0;
          end
        end
        LOCKED: begin
          if (rise) meas = 1'b1;
          if ((rise && !match) || timeout) begin
            state_next = FAULT;
            fault_set  = 1'b1;
          end
        end
        FAULT:   state_next = FAULT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    locked_o = 1'b0;
    if (state == LOCKED) locked_o = 1'b1;
  end

  // Stage p2: period counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      valid_o  <= 1'b0;
      period_o <= '0;
      err_o    <= 1'b0;
    end else begin
      valid_o <= meas;
      if (clr_i || !en_i || state == IDLE) begin
        cnt <= '0;
      end else if (rise) begin
        cnt <= CW'(1);
      end else begin
        cnt <= sat_inc(cnt);
      end
      if (clr_i) begin
        period_o <= '0;
        err_o    <= 1'b0;
      end else begin
        if (meas)      period_o <= cnt;
        if (fault_set) err_o    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Directed bench for clk_ratio_monitor: one instance at TOL=0, one at TOL=1.
module tb_clk_ratio_monitor;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, slow, slow1;
  logic       valid0, locked0, err0;
  logic       valid1, locked1, err1;
  logic [7:0] period0, period1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int vcnt0 = 0, vcnt1 = 0;
  int per0 = 0, per1 = 0;
  int vcyc0 = 0;
  int pstart = 0;
  int v;

  always #5 clk = ~clk;

  clk_ratio_monitor #(.RATIO(4), .TOL(0), .LOCK_CNT(4), .MAX_PERIOD(255)) dut0 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (en),
    .clr_i    (clr),
    .slow_i   (slow),
    .valid_o  (valid0),
    .period_o (period0),
    .locked_o (locked0),
    .err_o    (err0)
  );

  clk_ratio_monitor #(.RATIO(4), .TOL(1), .LOCK_CNT(4), .MAX_PERIOD(255)) dut1 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (en),
    .clr_i    (clr),
    .slow_i   (slow1),
    .valid_o  (valid1),
    .period_o (period1),
    .locked_o (locked1),
    .err_o    (err1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid0) begin
      vcnt0 <= vcnt0 + 1;
      per0  <= 32'(period0);
      vcyc0 <= cyc;
    end
    if (valid1) begin
      vcnt1 <= vcnt1 + 1;
      per1  <= 32'(period1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe followed by p-1 low cycles: rising edges p cycles apart.
  task automatic pulse(input int p);
    pstart = cyc;
    slow = 1'b1;
    tick(1);
    slow = 1'b0;
    tick(p - 1);
  endtask

  task automatic pulse1(input int p);
    slow1 = 1'b1;
    tick(1);
    slow1 = 1'b0;
    tick(p - 1);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; slow = 1'b0; slow1 = 1'b0;
    tick(3);
    chk("rst_valid",  32'(valid0),  0);
    chk("rst_period", 32'(period0), 0);
    chk("rst_locked", 32'(locked0), 0);
    chk("rst_err",    32'(err0),    0);
    rst_n = 1'b1;
    tick(2);
    en = 1'b1;
    tick(3);

    // Nominal clk/4: reference edge, then four matching periods to lock
    v = vcnt0;
    pulse(4);
    pulse(4);
    chk("t1_latency",   vcyc0 - pstart, 3);
    chk("t1_first_per", per0, 4);
    pulse(4);
    pulse(4);
    chk("t1_not_locked", 32'(locked0), 0);
    pulse(4);
    chk("t1_locked", 32'(locked0), 1);
    chk("t1_vcnt",   vcnt0 - v, 4);
    chk("t1_err",    32'(err0), 0);

    // One long period while locked: fault, and fault persists
    pulse(5);
    v = vcnt0;
    pulse(4);
    chk("t2_per",    per0, 5);
    chk("t2_vcnt",   vcnt0 - v, 1);
    chk("t2_err",    32'(err0), 1);
    chk("t2_locked", 32'(locked0), 0);
    pulse(4);
    pulse(4);
    chk("t2_fault_vcnt", vcnt0 - v, 1);
    chk("t2_fault_err",  32'(err0), 1);

    // Stuck-low while locked, then saturation check from ACQUIRE
    do_clr();
    chk("t3_clr_err", 32'(err0), 0);
    chk("t3_clr_per", 32'(period0), 0);
    v = vcnt0;
    repeat (5) pulse(4);
    chk("t3_relock_vcnt", vcnt0 - v, 4);
    chk("t3_relock",      32'(locked0), 1);
    tick(300);
    chk("t3_to_err",    32'(err0), 1);
    chk("t3_to_locked", 32'(locked0), 0);
    do_clr();
    chk("t3_clr2_err", 32'(err0), 0);
    chk("t3_clr2_per", 32'(period0), 0);
    v = vcnt0;
    pulse(4);
    chk("t3_armed_vcnt", vcnt0 - v, 0);
    tick(300);
    pulse(4);
    chk("t3_sat_per",  per0, 255);
    chk("t3_sat_vcnt", vcnt0 - v, 1);
    chk("t3_sat_err",  32'(err0), 0);

    // TOL=1 instance: 3,5,4,5 lock; a period of 6 restarts the run
    do_clr();
    v = vcnt1;
    pulse1(3);
    pulse1(5);
    pulse1(4);
    pulse1(5);
    chk("t4_not_locked", 32'(locked1), 0);
    pulse1(4);
    chk("t4_per",    per1, 5);
    chk("t4_vcnt",   vcnt1 - v, 4);
    chk("t4_locked", 32'(locked1), 1);
    do_clr();
    chk("t4_clr_locked", 32'(locked1), 0);
    pulse1(4);
    pulse1(4);
    pulse1(6);
    pulse1(4);
    chk("t4_per6",     per1, 6);
    chk("t4_per6_err", 32'(err1), 0);
    pulse1(4);
    pulse1(4);
    pulse1(4);
    chk("t4_restart_unlocked", 32'(locked1), 0);
    pulse1(4);
    chk("t4_restart_locked", 32'(locked1), 1);
    chk("t4_err", 32'(err1), 0);

    // clr coincident with an edge while locked discards the measurement
    do_clr();
    repeat (5) pulse(4);
    chk("t5_locked", 32'(locked0), 1);
    v = vcnt0;
    slow = 1'b1;
    tick(1);
    slow = 1'b0;
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(3);
    chk("t5_clr_vcnt",   vcnt0 - v, 0);
    chk("t5_clr_per",    32'(period0), 0);
    chk("t5_clr_locked", 32'(locked0), 0);
    pulse(4);
    chk("t5_armed_vcnt", vcnt0 - v, 0);
    repeat (4) pulse(4);
    chk("t5_relock", 32'(locked0), 1);
    en = 1'b0;
    tick(1);
    chk("t5_en_locked", 32'(locked0), 0);
    en = 1'b1;
    tick(2);
    v = vcnt0;
    pulse(4);
    chk("t5_idle_armed_vcnt", vcnt0 - v, 0);
    repeat (4) pulse(4);
    pulse(5);
    pulse(4);
    chk("t5_fault_err", 32'(err0), 1);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(1);
    chk("t5_en_err_kept", 32'(err0), 1);
    chk("t5_en_per_kept", 32'(period0), 5);
    chk("t5_en_unlocked", 32'(locked0), 0);

    // Async reset mid-ACQUIRE with slow high; no phantom edge afterwards
    do_clr();
    pulse(4);
    pulse(4);
    chk("t6_pre_per", 32'(period0), 4);
    slow = 1'b1;
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",  32'(valid0),  0);
    chk("t6_rst_per",    32'(period0), 0);
    chk("t6_rst_locked", 32'(locked0), 0);
    chk("t6_rst_err",    32'(err0),    0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    slow = 1'b0;
    tick(3);
    v = vcnt0;
    pulse(4);
    pulse(4);
    chk("t6_post_vcnt", vcnt0 - v, 1);
    chk("t6_post_per",  per0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
